// File: rtl/level_fifo_pkg.sv
// Shared widths and types for the level_fifo block.
// Pointer/count widths are derived from DEPTH so every file agrees on them.
package level_fifo_pkg;

    // Address width of the storage array; DEPTH is a power of two >= 2.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count needs one extra bit so that DEPTH itself is representable.
    function automatic int cnt_w(input int depth);
        return ptr_w(depth) + 1;
    endfunction

    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_flags_t;

endpackage

// File: rtl/level_fifo_mem.sv
// Storage for level_fifo: DEPTH x DATA_WIDTH register array, one write port
// and one synchronous read port whose output register holds between reads.
module level_fifo_mem
    import level_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [ptr_w(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      rd_en,
    input  logic [ptr_w(DEPTH)-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // The array itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/level_fifo.sv
// Synchronous FIFO with occupancy count and level flags.
// Define LEVEL_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module level_fifo
    import level_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      wren,
    input  logic [DATA_WIDTH-1:0]     i_data,
    input  logic                      rden,
    output logic [DATA_WIDTH-1:0]     o_data,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_THRESH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             wr_acc;
    logic             rd_acc;

    // A read frees a slot in the same cycle, so a full FIFO still accepts
    // a simultaneous write; flush overrides both requests.
    assign rd_acc = rden && !empty && !flush;
    assign wr_acc = wren && (!full || rden) && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count        = count_q;
    assign full         = (count_q == CNT_FULL);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);

    level_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (i_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (o_data)
    );

`ifdef LEVEL_FIFO_ERR_EN
    err_flags_t err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else if (flush) begin
            err_q <= '0;
        end else begin
            if (wren && full && !rden) begin
                err_q.overflow <= 1'b1;
            end
            if (rden && empty) begin
                err_q.underflow <= 1'b1;
            end
        end
    end

    assign overflow  = err_q.overflow;
    assign underflow = err_q.underflow;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_level_fifo.sv
// Directed self-checking bench for level_fifo at DEPTH=8, DATA_WIDTH=8.
// Expected flag values follow LEVEL_FIFO_ERR_EN when it is defined.
module tb_level_fifo;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       wren;
    logic [7:0] i_data;
    logic       rden;
    logic [7:0] o_data;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

`ifdef LEVEL_FIFO_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    level_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wren         (wren),
        .i_data       (i_data),
        .rden         (rden),
        .o_data       (o_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of requests; outputs are sampled 1 ns after the edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic f);
        wren   = w;
        i_data = d;
        rden   = r;
        flush  = f;
        @(posedge clk);
        #1;
        wren  = 1'b0;
        rden  = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        flush  = 1'b0;
        wren   = 1'b0;
        rden   = 1'b0;
        i_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);

        chk("rst_empty", empty, 1);
        chk("rst_ae", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_count", count, 0);
        chk("rst_odata", o_data, 8'h00);

        // single write / read / idle
        step(1'b1, 8'h01, 1'b0, 1'b0);
        chk("wr1_count", count, 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("rd1_odata", o_data, 8'h01);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("idle_odata", o_data, 8'h01);
        chk("idle_empty", empty, 1);

        // fill to full, crossing the pointer wrap
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 6) chk("af_at6", almost_full, 0);
            if (i == 7) begin
                chk("af_at7", almost_full, 1);
                chk("full_at7", full, 0);
            end
        end
        chk("full_at8", full, 1);
        chk("count_at8", count, 8);

        step(1'b1, 8'h09, 1'b1, 1'b0);
        chk("wrrd_full_odata", o_data, 8'h01);
        chk("wrrd_full_full", full, 1);
        chk("wrrd_full_count", count, 8);

        for (int i = 2; i <= 9; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk($sformatf("drain_%0d", i), o_data, 8'(i));
        end
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);

        // read on empty
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("uf_odata", o_data, 8'h09);
        chk("uf_count", count, 0);
        chk("uf_flag", underflow, ERR);

        // write+read on empty: write only, no bypass
        step(1'b1, 8'h40, 1'b1, 1'b0);
        chk("wrrd_empty_count", count, 1);
        chk("wrrd_empty_odata", o_data, 8'h09);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrrd_empty_rd", o_data, 8'h40);

        // overflow: write to full without read is dropped
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("of_count", count, 8);
        chk("of_flag", overflow, ERR);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk($sformatf("of_drain_%0d", i), o_data, 32'(8'h10 + i));
        end
        chk("of_drain_empty", empty, 1);
        chk("of_sticky", overflow, ERR);

        // flush with a concurrent write
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        chk("pre_flush_count", count, 5);
        step(1'b1, 8'h55, 1'b0, 1'b1);
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_odata", o_data, 8'h17);
        chk("flush_of", overflow, 0);
        chk("flush_uf", underflow, 0);

        // refill, then async reset mid-cycle
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        chk("refill_count", count, 3);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("refill_rd", o_data, 8'h30);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_ae", almost_empty, 1);
        chk("arst_full", full, 0);
        chk("arst_af", almost_full, 0);
        chk("arst_odata", o_data, 8'h00);
        chk("arst_of", overflow, 0);
        chk("arst_uf", underflow, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // first write after reset is the first read
        step(1'b1, 8'h61, 1'b0, 1'b0);
        step(1'b1, 8'h62, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_rd", o_data, 8'h61);
        chk("post_rst_count", count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/level_fifo.md
LEVEL_FIFO -- requirements
Module: level_fifo

Interface
REQ-001 DATA_WIDTH, 8, width of one entry in bits.
REQ-002 DEPTH, 8, number of entries; SHALL be a power of two and at least 2.
REQ-003 AF_THRESH, DEPTH-1, occupancy at or above which almost_full asserts.
REQ-004 AE_THRESH, 1, occupancy at or below which almost_empty asserts.
REQ-005 clk  input  1  single rising-edge clock for all state.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 flush  input  1  synchronous clear of contents.
REQ-008 wren  input  1  write request.
REQ-009 i_data  input  DATA_WIDTH  write data.
REQ-010 rden  input  1  read request.
REQ-011 o_data  output  DATA_WIDTH  registered read data.
REQ-012 full  output  1  occupancy equals DEPTH.
REQ-013 empty  output  1  occupancy equals 0.
REQ-014 almost_full  output  1  occupancy >= AF_THRESH.
REQ-015 almost_empty  output  1  occupancy <= AE_THRESH.
REQ-016 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-017 overflow  output  1  sticky: a write was dropped.
REQ-018 underflow  output  1  sticky: a read hit an empty FIFO.

Function
REQ-019 A write SHALL be accepted when wren && (!full || rden); i_data is stored at wr_ptr and wr_ptr advances by one modulo DEPTH.
REQ-020 A read SHALL be accepted when rden && !empty; o_data loads mem[rd_ptr] on that edge (1-cycle latency) and rd_ptr advances by one modulo DEPTH.
REQ-021 o_data SHALL hold its value on every cycle without an accepted read, including reads on empty.
REQ-022 A write and a read in the same cycle while full SHALL both be accepted: o_data = oldest entry, count unchanged, full stays 1.
REQ-023 A write and a read in the same cycle while empty SHALL perform the write only: o_data holds, count becomes 1, no bypass.
REQ-024 A write while full without a read SHALL be dropped, leaving contents and pointers unchanged.
REQ-025 count SHALL increment on write-only, decrement on read-only, and hold when both or neither occur.
REQ-026 full, empty, almost_full and almost_empty SHALL be decoded combinationally from count.
REQ-027 Pointers SHALL wrap from DEPTH-1 to 0 with no bubble cycle.
REQ-028 flush SHALL zero the pointers, count, overflow and underflow on the next edge, takes priority over wren/rden in the same cycle, and leaves o_data unchanged.

Reset
REQ-029 While rst is high, the pointers, count, o_data, overflow and underflow SHALL be 0 immediately (asynchronous), giving empty=1, almost_empty=1, full=0, almost_full=0.
REQ-030 The storage array SHALL NOT be reset; contents present before a reset mid-operation are discarded logically.
REQ-031 The first accepted write after rst deasserts SHALL be the first data read.

Configuration
REQ-032 With LEVEL_FIFO_ERR_EN defined, overflow SHALL set on wren && full && !rden and underflow SHALL set on rden && empty; each stays set until rst or flush.
REQ-033 Without LEVEL_FIFO_ERR_EN, overflow and underflow SHALL remain as ports tied to 0, with no flops generated.

Structure
REQ-034 Package level_fifo_pkg SHALL hold the pointer and count width function, derived from DEPTH, and the error-flag typedef.
REQ-035 Storage SHALL be the sub-module level_fifo_mem: a DEPTH x DATA_WIDTH register array with one write port and one synchronous read port. Pointers, count, flags and the error logic stay in level_fifo.

Verification (DEPTH=8, DATA_WIDTH=8, defaults)
REQ-036 Assert rst, then idle -> empty=1, almost_empty=1, full=0, count=0, o_data=0x00.
REQ-037 Write 0x01, then read, then idle -> o_data=0x01 after the read edge and still 0x01 after the idle cycle; empty=1.
REQ-038 Write 0x01..0x08 -> almost_full=1 after the 7th write, full=1 and count=8 after the 8th; then wren+rden with 0x09 -> o_data=0x01, full stays 1; then 8 reads -> o_data 0x02..0x09, empty=1 after the last.
REQ-039 Read on empty -> o_data holds 0x09, count=0, underflow=1 (ERR_EN defined) or 0 (not defined).
REQ-040 Fill 8 entries, then write 0xAA without a read -> dropped, overflow=1 (ERR_EN defined), and the drain order is unchanged.
REQ-041 Write 5 entries, then flush with wren=1 -> count=0, empty=1, o_data unchanged; refill 3 entries and assert rst asynchronously mid-cycle -> all outputs take their reset values before the next edge.
